// File: rtl/tt_bist_pkg.sv
// Shared types and the shift-with-feedback step used by both the
// stimulus LFSR and the response MISR of the BIST harness.
package tt_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } bist_state_t;

    // Widest register the helper supports; callers zero-extend and truncate.
    localparam int SHREG_MAX_W = 32;

    function automatic logic [SHREG_MAX_W-1:0] shift_fb(
        input logic [SHREG_MAX_W-1:0] value,
        input logic [SHREG_MAX_W-1:0] taps
    );
        return {value[SHREG_MAX_W-2:0], ^(value & taps)};
    endfunction

endpackage

// File: rtl/tt_bist_shreg.sv
// Shift register with parity feedback and an XOR input; serves as the
// LFSR (xor_i tied low) or the MISR (xor_i carries the response).
module tt_bist_shreg
    import tt_bist_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] xor_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load_i) begin
            q_d = load_val_i;
        end else if (shift_i) begin
            q_d = WIDTH'(shift_fb(SHREG_MAX_W'(q_q), SHREG_MAX_W'(POLY))) ^ xor_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/tt_bist_harness.sv
// BIST harness: LFSR stimulus into a wrapped datapath, MISR compaction of
// the returned responses, and a golden-signature compare.
//   state    | meaning
//   ST_IDLE  | waiting for start, outputs quiet
//   ST_RUN   | driving N_PATTERNS stimulus vectors
//   ST_DRAIN | LAT cycles absorbing in-flight responses
//   ST_DONE  | signature final, pass valid, start re-arms
module tt_bist_harness
    import tt_bist_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] POLY       = WIDTH'(8'hB8),
    parameter logic [WIDTH-1:0] SEED       = WIDTH'(1),
    parameter int               N_PATTERNS = 255,
    parameter int               LAT        = 1,
    parameter logic [WIDTH-1:0] GOLDEN     = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ena_i,
    input  logic             start_i,
    output logic [WIDTH-1:0] stim_out_o,
    output logic             stim_valid_o,
    input  logic [WIDTH-1:0] resp_in_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [WIDTH-1:0] signature_o
);

    localparam int               CNT_W      = $clog2(N_PATTERNS + LAT + 1);
    localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(N_PATTERNS - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(N_PATTERNS + LAT - 1);

    bist_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             launch;
    logic             advance;
    logic             cap_window;
    logic             capture;
    logic [WIDTH-1:0] lfsr;
    logic [WIDTH-1:0] misr;

    assign launch  = ena_i && start_i && (state_q == ST_IDLE || state_q == ST_DONE);
    assign advance = ena_i && (state_q == ST_RUN || state_q == ST_DRAIN);

    // cnt is the cycle index k since the first RUN cycle; responses arrive LAT late.
    if (LAT == 0) begin : g_no_lat
        assign cap_window = 1'b1;
    end else begin : g_lat
        assign cap_window = (cnt_q >= CNT_W'(LAT));
    end
    assign capture = advance && cap_window;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (launch) state_d = ST_RUN;
            ST_RUN:   if (ena_i && cnt_q == RUN_LAST) state_d = (LAT > 0) ? ST_DRAIN : ST_DONE;
            ST_DRAIN: if (ena_i && cnt_q == DRAIN_LAST) state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (launch) begin
            cnt_d = '0;
        end else if (advance) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        stim_out_o   = '0;
        stim_valid_o = 1'b0;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        pass_o       = 1'b0;
        case (state_q)
            ST_RUN: begin
                stim_out_o   = lfsr;
                stim_valid_o = 1'b1;
                busy_o       = 1'b1;
            end
            ST_DRAIN: busy_o = 1'b1;
            ST_DONE: begin
                done_o = 1'b1;
                pass_o = (misr == GOLDEN);
            end
            default: ;
        endcase
    end

    tt_bist_shreg #(.WIDTH(WIDTH), .POLY(POLY)) u_lfsr (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (launch),
        .load_val_i (SEED),
        .shift_i    (ena_i && state_q == ST_RUN),
        .xor_i      ('0),
        .q_o        (lfsr)
    );

    tt_bist_shreg #(.WIDTH(WIDTH), .POLY(POLY)) u_misr (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (launch),
        .load_val_i ('0),
        .shift_i    (capture),
        .xor_i      (resp_in_i),
        .q_o        (misr)
    );

    assign signature_o = misr;

endmodule

// File: tb/tb_tt_bist_harness.sv
// Bench for tt_bist_harness: a loopback instance (LAT=0) and a piped
// instance (LAT=3), checked against a behavioural signature model.
module tb_tt_bist_harness;

    localparam logic [3:0] TB_POLY = 4'h9;

    function automatic logic [3:0] fb_shift(input logic [3:0] v);
        logic p;
        p = 1'b0;
        for (int b = 0; b < 4; b++) if (TB_POLY[b]) p = p ^ v[b];
        return {v[2:0], p};
    endfunction

    function automatic logic [3:0] misr_step(input logic [3:0] m, input logic [3:0] r);
        return fb_shift(m) ^ r;
    endfunction

    // Signature of a loopback run, optionally with bit 0 flipped on one pattern.
    function automatic logic [3:0] model_sig(input int fault_pat);
        logic [3:0] pat, m;
        pat = 4'h1;
        m   = 4'h0;
        for (int i = 0; i < 15; i++) begin
            m   = misr_step(m, pat ^ ((i == fault_pat) ? 4'h1 : 4'h0));
            pat = fb_shift(pat);
        end
        return m;
    endfunction

    localparam logic [3:0] GOLD = model_sig(-1);

    logic [3:0] exp_seq [15] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hA, 4'h5,
                                 4'hB, 4'h6, 4'hC, 4'h9, 4'h2, 4'h4, 4'h8};
    logic [3:0] rec_a [15];

    logic       clk;
    logic       rst_a, ena_a, start_a, fault_a;
    logic [3:0] stim_a, resp_a, sig_a;
    logic       valid_a, busy_a, done_a, pass_a;
    logic       rst_b, ena_b, start_b, rnd_mode_b;
    logic [3:0] stim_b, resp_b, sig_b, rnd_val_b;
    logic       valid_b, busy_b, done_b, pass_b;
    logic [3:0] p1, p2, p3;

    int n_checks = 0;
    int n_errors = 0;

    assign resp_a = stim_a ^ {3'b000, fault_a};
    assign resp_b = rnd_mode_b ? rnd_val_b : p3;

    always_ff @(posedge clk) begin
        p1 <= stim_b;
        p2 <= p1;
        p3 <= p2;
    end

    tt_bist_harness #(.WIDTH(4), .POLY(4'h9), .SEED(4'h1), .N_PATTERNS(15),
                      .LAT(0), .GOLDEN(GOLD)) dut_a (
        .clk_i(clk), .rst_i(rst_a), .ena_i(ena_a), .start_i(start_a),
        .stim_out_o(stim_a), .stim_valid_o(valid_a), .resp_in_i(resp_a),
        .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a), .signature_o(sig_a)
    );

    tt_bist_harness #(.WIDTH(4), .POLY(4'h9), .SEED(4'h1), .N_PATTERNS(15),
                      .LAT(3), .GOLDEN(GOLD)) dut_b (
        .clk_i(clk), .rst_i(rst_b), .ena_i(ena_b), .start_i(start_b),
        .stim_out_o(stim_b), .stim_valid_o(valid_b), .resp_in_i(resp_b),
        .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b), .signature_o(sig_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_a(input int fault_pat, input int freeze_at, input int freeze_len,
                         output int cyc, output int nv, output logic hold_ok,
                         output logic first_busy, output logic [3:0] first_stim);
        logic [3:0] snap_stim, snap_sig;
        snap_stim = '0;
        snap_sig  = '0;
        ena_a   = 1'b1;
        start_a = 1'b1;
        tick();
        start_a    = 1'b0;
        first_busy = busy_a;
        first_stim = stim_a;
        cyc = 0;
        nv  = 0;
        hold_ok = 1'b1;
        while (done_a !== 1'b1 && cyc < 200) begin
            ena_a = !(freeze_at >= 0 && cyc >= freeze_at && cyc < freeze_at + freeze_len);
            if (cyc == freeze_at) begin
                snap_stim = stim_a;
                snap_sig  = sig_a;
            end
            if (!ena_a && (stim_a !== snap_stim || sig_a !== snap_sig)) hold_ok = 1'b0;
            fault_a = 1'b0;
            if (valid_a === 1'b1 && ena_a) begin
                if (nv < 15) rec_a[nv] = stim_a;
                fault_a = (nv == fault_pat);
                nv++;
            end
            tick();
            cyc++;
        end
        ena_a   = 1'b1;
        fault_a = 1'b0;
    endtask

    task automatic run_b(input logic rnd, input int off_pct, output int cyc,
                         output int drain, output int off, output int ncap,
                         output logic [3:0] exp_sig);
        int k;
        ena_b      = 1'b1;
        rnd_mode_b = rnd;
        start_b    = 1'b1;
        tick();
        start_b = 1'b0;
        cyc = 0; drain = 0; off = 0; ncap = 0; k = 0;
        exp_sig = 4'h0;
        while (done_b !== 1'b1 && cyc < 300) begin
            ena_b     = (off_pct == 0) ? 1'b1 : ($urandom_range(0, 99) >= off_pct);
            rnd_val_b = 4'($urandom);
            if (!ena_b) begin
                off++;
            end else if (busy_b === 1'b1) begin
                if (valid_b === 1'b0) drain++;
                if (k >= 3) begin
                    exp_sig = misr_step(exp_sig, rnd_val_b);
                    ncap++;
                end
                k++;
            end
            tick();
            cyc++;
        end
        ena_b      = 1'b1;
        rnd_mode_b = 1'b0;
    endtask

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1;
        ena_a = 1'b1; ena_b = 1'b1;
        start_a = 1'b1; start_b = 1'b1;
        tick();
        tick();
        n_checks++; if (stim_a !== 4'h0) begin n_errors++; $display("FAIL reset_stim got=%h want=0", stim_a); end
        n_checks++; if (valid_a !== 1'b0) begin n_errors++; $display("FAIL reset_valid got=%b want=0", valid_a); end
        n_checks++; if (busy_a !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%b want=0", busy_a); end
        n_checks++; if (done_a !== 1'b0) begin n_errors++; $display("FAIL reset_done got=%b want=0", done_a); end
        n_checks++; if (pass_a !== 1'b0) begin n_errors++; $display("FAIL reset_pass got=%b want=0", pass_a); end
        n_checks++; if (sig_a !== 4'h0) begin n_errors++; $display("FAIL reset_sig got=%h want=0", sig_a); end
        n_checks++; if (busy_b !== 1'b0) begin n_errors++; $display("FAIL reset_busy_b got=%b want=0", busy_b); end
        start_a = 1'b0; start_b = 1'b0;
        rst_a = 1'b0; rst_b = 1'b0;
        fault_a = 1'b0; rnd_mode_b = 1'b0; rnd_val_b = 4'h0;
        tick();
        n_checks++; if (busy_a !== 1'b0) begin n_errors++; $display("FAIL idle_no_start got=%b want=0", busy_a); end
    endtask

    task automatic test_sequence();
        int cyc, nv;
        logic hold_ok, fb;
        logic [3:0] fs;
        run_a(-1, -1, 0, cyc, nv, hold_ok, fb, fs);
        n_checks++; if (fb !== 1'b1) begin n_errors++; $display("FAIL seq_busy_rise got=%b want=1", fb); end
        n_checks++; if (fs !== 4'h1) begin n_errors++; $display("FAIL seq_first_stim got=%h want=1", fs); end
        n_checks++; if (nv != 15) begin n_errors++; $display("FAIL seq_valid_cycles got=%0d want=15", nv); end
        n_checks++; if (cyc != 15) begin n_errors++; $display("FAIL seq_done_latency got=%0d want=15", cyc); end
        for (int i = 0; i < 15; i++) begin
            n_checks++;
            if (rec_a[i] !== exp_seq[i]) begin
                n_errors++;
                $display("FAIL seq_pattern[%0d] got=%h want=%h", i, rec_a[i], exp_seq[i]);
            end
        end
        n_checks++; if (valid_a !== 1'b0) begin n_errors++; $display("FAIL seq_valid_in_done got=%b want=0", valid_a); end
    endtask

    task automatic test_golden();
        n_checks++; if (pass_a !== 1'b1) begin n_errors++; $display("FAIL golden_pass got=%b want=1", pass_a); end
        n_checks++; if (sig_a !== GOLD) begin n_errors++; $display("FAIL golden_sig got=%h want=%h", sig_a, GOLD); end
        tick();
        tick();
        n_checks++; if (done_a !== 1'b1 || sig_a !== GOLD) begin n_errors++; $display("FAIL golden_held done=%b sig=%h want done=1 sig=%h", done_a, sig_a, GOLD); end
    endtask

    task automatic test_restart();
        int cyc, nv;
        logic hold_ok, fb;
        logic [3:0] fs;
        run_a(-1, -1, 0, cyc, nv, hold_ok, fb, fs);
        n_checks++; if (fs !== 4'h1) begin n_errors++; $display("FAIL restart_first_stim got=%h want=1", fs); end
        n_checks++; if (cyc != 15) begin n_errors++; $display("FAIL restart_latency got=%0d want=15", cyc); end
        n_checks++; if (sig_a !== GOLD) begin n_errors++; $display("FAIL restart_sig got=%h want=%h", sig_a, GOLD); end
        n_checks++; if (pass_a !== 1'b1) begin n_errors++; $display("FAIL restart_pass got=%b want=1", pass_a); end
    endtask

    task automatic test_fault();
        int cyc, nv, fp;
        logic hold_ok, fb;
        logic [3:0] fs, want;
        for (int r = 0; r < 4; r++) begin
            fp   = (r == 0) ? 7 : int'($urandom_range(0, 14));
            want = model_sig(fp);
            run_a(fp, -1, 0, cyc, nv, hold_ok, fb, fs);
            n_checks++; if (pass_a !== 1'b0) begin n_errors++; $display("FAIL fault%0d_pass got=%b want=0", fp, pass_a); end
            n_checks++; if (sig_a === GOLD) begin n_errors++; $display("FAIL fault%0d_sig_differs got=%h want!=%h", fp, sig_a, GOLD); end
            n_checks++; if (sig_a !== want) begin n_errors++; $display("FAIL fault%0d_sig got=%h want=%h", fp, sig_a, want); end
        end
    endtask

    task automatic test_freeze();
        int cyc, nv, fa, fl;
        logic hold_ok, fb;
        logic [3:0] fs;
        for (int r = 0; r < 3; r++) begin
            fa = (r == 0) ? 5 : int'($urandom_range(0, 13));
            fl = (r == 0) ? 5 : int'($urandom_range(1, 7));
            run_a(-1, fa, fl, cyc, nv, hold_ok, fb, fs);
            n_checks++; if (hold_ok !== 1'b1) begin n_errors++; $display("FAIL freeze_hold at=%0d got=%b want=1", fa, hold_ok); end
            n_checks++; if (cyc != 15 + fl) begin n_errors++; $display("FAIL freeze_latency got=%0d want=%0d", cyc, 15 + fl); end
            n_checks++; if (nv != 15) begin n_errors++; $display("FAIL freeze_patterns got=%0d want=15", nv); end
            n_checks++; if (pass_a !== 1'b1 || sig_a !== GOLD) begin n_errors++; $display("FAIL freeze_result pass=%b sig=%h want pass=1 sig=%h", pass_a, sig_a, GOLD); end
        end
    endtask

    task automatic test_latency();
        int cyc, drain, off, ncap;
        logic [3:0] es;
        run_b(1'b0, 0, cyc, drain, off, ncap, es);
        n_checks++; if (cyc != 18) begin n_errors++; $display("FAIL lat_done_latency got=%0d want=18", cyc); end
        n_checks++; if (drain != 3) begin n_errors++; $display("FAIL lat_drain_cycles got=%0d want=3", drain); end
        n_checks++; if (pass_b !== 1'b1) begin n_errors++; $display("FAIL lat_pass got=%b want=1", pass_b); end
        n_checks++; if (sig_b !== GOLD) begin n_errors++; $display("FAIL lat_sig got=%h want=%h", sig_b, GOLD); end
    endtask

    task automatic test_random();
        int cyc, drain, off, ncap;
        logic [3:0] es;
        for (int r = 0; r < 5; r++) begin
            run_b(1'b1, 30, cyc, drain, off, ncap, es);
            n_checks++; if (ncap != 15) begin n_errors++; $display("FAIL rnd%0d_captures got=%0d want=15", r, ncap); end
            n_checks++; if (cyc != 18 + off) begin n_errors++; $display("FAIL rnd%0d_latency got=%0d want=%0d", r, cyc, 18 + off); end
            n_checks++; if (sig_b !== es) begin n_errors++; $display("FAIL rnd%0d_sig got=%h want=%h", r, sig_b, es); end
            n_checks++; if (pass_b !== (es == GOLD)) begin n_errors++; $display("FAIL rnd%0d_pass got=%b want=%b", r, pass_b, (es == GOLD)); end
        end
    endtask

    task automatic test_reset_mid_drain();
        int guard, cyc, drain, off, ncap;
        logic [3:0] es;
        ena_b   = 1'b1;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        guard   = 0;
        while (!(busy_b === 1'b1 && valid_b === 1'b0) && guard < 100) begin
            tick();
            guard++;
        end
        n_checks++; if (guard != 15) begin n_errors++; $display("FAIL mid_reach_drain got=%0d want=15", guard); end
        tick();
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        n_checks++; if (stim_b !== 4'h0 || valid_b !== 1'b0) begin n_errors++; $display("FAIL mid_rst_stim stim=%h valid=%b want 0/0", stim_b, valid_b); end
        n_checks++; if (busy_b !== 1'b0 || done_b !== 1'b0) begin n_errors++; $display("FAIL mid_rst_flags busy=%b done=%b want 0/0", busy_b, done_b); end
        n_checks++; if (pass_b !== 1'b0 || sig_b !== 4'h0) begin n_errors++; $display("FAIL mid_rst_result pass=%b sig=%h want 0/0", pass_b, sig_b); end
        tick();
        tick();
        n_checks++; if (busy_b !== 1'b0 || done_b !== 1'b0) begin n_errors++; $display("FAIL mid_rst_stays_idle busy=%b done=%b want 0/0", busy_b, done_b); end
        run_b(1'b0, 0, cyc, drain, off, ncap, es);
        n_checks++; if (cyc != 18 || sig_b !== GOLD || pass_b !== 1'b1) begin n_errors++; $display("FAIL mid_rst_rerun cyc=%0d sig=%h pass=%b want 18/%h/1", cyc, sig_b, pass_b, GOLD); end
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        ena_a = 1'b0; ena_b = 1'b0;
        start_a = 1'b0; start_b = 1'b0;
        fault_a = 1'b0; rnd_mode_b = 1'b0; rnd_val_b = 4'h0;
        test_reset();
        test_sequence();
        test_golden();
        test_restart();
        test_fault();
        test_freeze();
        test_latency();
        test_random();
        test_reset_mid_drain();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tt_bist_harness.md
# tt_bist_harness

Parametrised on-chip built-in self-test harness for TinyTapeout user projects. An LFSR drives pseudo-random stimulus into a wrapped datapath, and a MISR compacts the returned responses into a signature. The signature is then compared against a golden constant. It sits between the `ui_in`/`uo_out` pads and the user logic, so the same directed check the cocotb bench performs can run on silicon, with pass/fail visible on output pins.

## Interface
Parameters:
- `WIDTH`, 8: stimulus/response width in bits (≥ 2).
- `POLY`, 8'hB8: tap mask shared by the LFSR and MISR, WIDTH bits.
- `SEED`, 1: LFSR reset/start value; must be non-zero.
- `N_PATTERNS`, 255: stimulus vectors per run (≥ 1).
- `LAT`, 1: wrapped-datapath latency in cycles (≥ 0).
- `GOLDEN`, 0: expected final MISR signature, WIDTH bits.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `ena`, in, 1: advance enable. When low, all state freezes.
- `start`, in, 1: single-cycle start pulse. Sampled in IDLE or DONE.
- `stim_out`, out, WIDTH: stimulus to the wrapped datapath.
- `stim_valid`, out, 1: high while `stim_out` carries a pattern.
- `resp_in`, in, WIDTH: response from the wrapped datapath.
- `busy`, out, 1: high in RUN and DRAIN.
- `done`, out, 1: high in DONE.
- `pass`, out, 1: signature equals GOLDEN. Meaningful only when `done`=1.
- `signature`, out, WIDTH: current MISR value.

## Operation
- State machine states: IDLE, RUN, DRAIN, DONE. All transitions are qualified by `ena`=1.
- IDLE: if `start`=1, then lfsr←SEED, misr←0, cnt←0, go to RUN.
- RUN: `stim_out`=lfsr and `stim_valid`=1. Each cycle: lfsr←{lfsr[W-2:0], ^(lfsr & POLY)} and cnt←cnt+1.
  - After cnt reaches N_PATTERNS−1: go to DRAIN if LAT>0, otherwise go to DONE.
- DRAIN: `stim_out`=0 and `stim_valid`=0. Lasts exactly LAT cycles, then go to DONE.
- MISR capture: in cycle k, counted from the first RUN cycle (k=0), capture only when LAT ≤ k < N_PATTERNS+LAT.
  - Capture update: misr←{misr[W-2:0], ^(misr & POLY)} ^ `resp_in`.
  - Exactly N_PATTERNS responses are absorbed per run.
- DONE: `done`=1. `pass`=(misr==GOLDEN), registered and held. `start`=1 restarts exactly as from IDLE.
- `start` is ignored in RUN and DRAIN.
- `ena`=0 in any state: lfsr, misr, cnt and state all hold. A capture cycle that is frozen is not counted.
- `cnt` width: $clog2(N_PATTERNS+LAT+1). It never wraps within a run.

## Timing
- Reset values: state=IDLE, `stim_out`=0, `stim_valid`=0, `busy`=0, `done`=0, `pass`=0, `signature`=0.
- `rst` takes priority over `start` and `ena` in the same cycle.
- `rst` in mid-run returns the block to IDLE on the next edge. No partial result is retained.
- Start latency: `start` sampled on edge t, first pattern (=SEED) visible after t, `busy` rises with it.
- Run length: RUN is N_PATTERNS cycles and DRAIN is LAT cycles (with `ena` held high).
- `done` rises exactly N_PATTERNS+LAT cycles after `busy` rises.
- Outputs are registered. There is no combinational path from `resp_in` to any output.

## Structure
- Shared package `tt_bist_pkg` holds:
  - the state enum `bist_state_t`;
  - the shift-with-feedback function used by both the LFSR and MISR.
- One sub-module, `tt_bist_shreg`, is natural. It is a WIDTH/POLY-parametrised shift register with feedback and an optional XOR input.
  - Instantiated twice: as the LFSR (XOR input tied to 0) and as the MISR (XOR input = `resp_in`, gated by capture).

## Test plan
- Sequence check. WIDTH=4, POLY=4'h9, SEED=1, N_PATTERNS=15, LAT=0, loopback (`resp_in`=`stim_out`), pulse `start`.
  - Required: `stim_out` = 1,3,7,F,E,D,A,5,B,6,C,9,2,4,8, `stim_valid` high for exactly 15 cycles, `done` 15 cycles after `busy`.
- Golden signature. Same setup, with GOLDEN set to the MISR value computed by the bench model.
  - Required: `pass`=1 and `signature`=GOLDEN.
- Single fault. Same setup, with `resp_in` bit 0 inverted on pattern 7 only.
  - Required: `pass`=0 and `signature`≠GOLDEN.
- Latency. LAT=3, with a 3-stage register pipe as the wrapped datapath.
  - Required: DRAIN lasts 3 cycles, `done` at N_PATTERNS+3 cycles, `pass`=1 with GOLDEN matching the loopback case.
- Freeze. Hold `ena` low for 5 cycles mid-RUN.
  - Required: `stim_out` and `signature` are held, `done` is delayed by exactly 5 cycles, final `pass` is unchanged.
- Reset and restart.
  - `rst` pulse during DRAIN: all outputs return to their reset values.
  - `start` in DONE: restarts with `stim_out`=SEED and reproduces an identical signature.
